// File: rtl/pkt_sched.sv
`timescale 1ns/1ps
// Capture-record scheduler: reserves space in a circular DDR buffer for each
// packet descriptor, starts wr_ctrl, then advances the write pointer.
//   state      | meaning
//   IDLE       | waiting for enable and a descriptor
//   CHECK      | space check, drop or reserve
//   ISSUE      | waiting for wr_ctrl_rdy, then start strobe + ack
//   WAIT_START | waiting for wr_ctrl_rdy to fall (bounded by START_TMO)
//   WAIT_DONE  | waiting for wr_ctrl_rdy to return
//   ADVANCE    | commit write pointer and record count
module pkt_sched #(
    parameter int HDR_BYTES = 16,
    parameter int START_TMO = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cfg_enable,
    input  logic [31:0] cfg_base,
    input  logic [31:0] cfg_size,
    input  logic [31:0] host_rd_ptr,
    input  logic        pkt_valid,
    input  logic [15:0] pkt_len,
    output logic        pkt_ack,
    output logic        wr_ctrl,
    output logic [31:0] control,
    output logic [31:0] pkt_begin,
    output logic [31:0] pkt_end,
    output logic [31:0] write_address,
    input  logic        wr_ctrl_rdy,
    output logic [31:0] wr_ptr,
    output logic [31:0] pkt_count,
    output logic [31:0] drop_count,
    output logic        err,
    output logic        busy
);

    localparam int TMO_W = (START_TMO > 1) ? $clog2(START_TMO) : 1;

    typedef enum logic [2:0] {
        IDLE, CHECK, ISSUE, WAIT_START, WAIT_DONE, ADVANCE
    } state_t;

    state_t state, state_nxt;

    logic             en_q;
    logic [31:0]      base_q, size_q, off_q;
    logic [16:0]      pad_q;
    logic [TMO_W-1:0] tmo_cnt;
    logic             load_rec, set_err;

    logic [16:0] pad_c, rec_c, rec_q;
    logic [31:0] used_c, free_c, tail_c, off_c, next_ptr;
    logic [32:0] end_c;
    logic        wrap_c, drop_c;

    assign pad_c  = ({1'b0, pkt_len} + 17'd3) & ~17'd3;
    assign rec_c  = 17'(HDR_BYTES) + pad_c;
    assign used_c = (wr_ptr >= host_rd_ptr) ? (wr_ptr - host_rd_ptr)
                                            : (wr_ptr - host_rd_ptr + size_q);
    // One word stays empty so that equal pointers unambiguously mean empty.
    assign free_c = size_q - used_c - 32'd4;
    assign end_c  = {1'b0, wr_ptr} + {16'b0, rec_c};
    assign wrap_c = end_c > {1'b0, size_q};
    assign tail_c = wrap_c ? (size_q - wr_ptr) : 32'd0;
    assign off_c  = wrap_c ? 32'd0 : wr_ptr;
    assign drop_c = ({1'b0, tail_c} + {16'b0, rec_c}) > {1'b0, free_c};

    assign rec_q    = 17'(HDR_BYTES) + pad_q;
    assign next_ptr = off_q + {15'b0, rec_q};

    assign pkt_begin = 32'd0;
    assign busy      = (state != IDLE);

    always_comb begin
        state_nxt = state;
        wr_ctrl   = 1'b0;
        pkt_ack   = 1'b0;
        load_rec  = 1'b0;
        set_err   = 1'b0;
        case (state)
            IDLE: begin
                if (cfg_enable && pkt_valid) state_nxt = CHECK;
            end
            CHECK: begin
                if (drop_c) begin
                    pkt_ack   = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    load_rec  = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (wr_ctrl_rdy) begin
                    wr_ctrl   = 1'b1;
                    pkt_ack   = 1'b1;
                    state_nxt = WAIT_START;
                end
            end
            WAIT_START: begin
                if (!wr_ctrl_rdy) begin
                    state_nxt = WAIT_DONE;
                end else if (tmo_cnt == '0) begin
                    set_err   = 1'b1;
                    state_nxt = ADVANCE;
                end
            end
            WAIT_DONE: begin
                if (wr_ctrl_rdy) state_nxt = ADVANCE;
            end
            ADVANCE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            en_q          <= 1'b0;
            base_q        <= 32'd0;
            size_q        <= 32'd0;
            off_q         <= 32'd0;
            pad_q         <= 17'd0;
            tmo_cnt       <= '0;
            wr_ptr        <= 32'd0;
            pkt_count     <= 32'd0;
            drop_count    <= 32'd0;
            err           <= 1'b0;
            write_address <= 32'd0;
            pkt_end       <= 32'd0;
            control       <= 32'd0;
        end else begin
            state <= state_nxt;
            // Edge tracking only in IDLE so a rise during a record is seen afterwards.
            if (state == IDLE) begin
                en_q <= cfg_enable;
                if (cfg_enable && !en_q) begin
                    wr_ptr <= 32'd0;
                    base_q <= cfg_base;
                    size_q <= cfg_size;
                end
            end
            if (state == CHECK && drop_c) drop_count <= drop_count + 32'd1;
            if (load_rec) begin
                off_q         <= off_c;
                pad_q         <= pad_c;
                write_address <= base_q + off_c;
                pkt_end       <= {15'b0, pad_c};
                control       <= {16'b0, pkt_len};
            end
            if (wr_ctrl)
                tmo_cnt <= TMO_W'(START_TMO - 1);
            else if (state == WAIT_START && tmo_cnt != '0)
                tmo_cnt <= tmo_cnt - TMO_W'(1);
            if (set_err) err <= 1'b1;
            if (state == ADVANCE) begin
                wr_ptr    <= (next_ptr == size_q) ? 32'd0 : next_ptr;
                pkt_count <= pkt_count + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_pkt_sched.sv
`timescale 1ns/1ps
// Directed bench for pkt_sched: basic write, padding, wrap, drop, timeout, reset.
module tb_pkt_sched;

    logic        clk;
    logic        reset_n;
    logic        cfg_enable;
    logic [31:0] cfg_base, cfg_size, host_rd_ptr;
    logic        pkt_valid;
    logic [15:0] pkt_len;
    logic        pkt_ack, wr_ctrl;
    logic [31:0] control, pkt_begin, pkt_end, write_address;
    logic        wr_ctrl_rdy;
    logic [31:0] wr_ptr, pkt_count, drop_count;
    logic        err, busy;

    int checks, failures;
    int model_busy;
    int ack_cnt, wrc_cnt;
    int lat;
    logic        got, s_wrc;
    logic [31:0] s_addr, s_end, s_ctrl, s_begin;

    pkt_sched dut (
        .clk(clk), .reset_n(reset_n), .cfg_enable(cfg_enable),
        .cfg_base(cfg_base), .cfg_size(cfg_size), .host_rd_ptr(host_rd_ptr),
        .pkt_valid(pkt_valid), .pkt_len(pkt_len), .pkt_ack(pkt_ack),
        .wr_ctrl(wr_ctrl), .control(control), .pkt_begin(pkt_begin),
        .pkt_end(pkt_end), .write_address(write_address),
        .wr_ctrl_rdy(wr_ctrl_rdy), .wr_ptr(wr_ptr), .pkt_count(pkt_count),
        .drop_count(drop_count), .err(err), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // wr_ctrl model: after a start, rdy drops for model_busy cycles (0 = never drops)
    initial begin
        wr_ctrl_rdy = 1'b1;
        forever begin
            @(negedge clk);
            if (wr_ctrl && model_busy != 0) begin
                @(posedge clk); #1;
                wr_ctrl_rdy = 1'b0;
                repeat (model_busy) @(posedge clk);
                #1;
                wr_ctrl_rdy = 1'b1;
            end
        end
    end

    initial begin
        ack_cnt = 0;
        wrc_cnt = 0;
        forever begin
            @(posedge clk);
            if (pkt_ack) ack_cnt++;
            if (wr_ctrl) wrc_cnt++;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Present a descriptor at a falling edge and snapshot outputs at the ack.
    task automatic send(input logic [15:0] len);
        got = 1'b0;
        lat = 0;
        pkt_len = len;
        pkt_valid = 1'b1;
        for (int i = 1; i <= 10 && !got; i++) begin
            @(negedge clk);
            if (pkt_ack) begin
                got = 1'b1;
                lat = i;
                s_wrc = wr_ctrl;
                s_addr = write_address;
                s_end = pkt_end;
                s_ctrl = control;
                s_begin = pkt_begin;
            end
        end
        pkt_valid = 1'b0;
        chk("ack_seen", {31'b0, got}, 32'd1);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk(tag, {31'b0, busy}, 32'd0);
    endtask

    initial begin
        checks = 0;
        failures = 0;
        model_busy = 70;
        reset_n = 1'b1;
        cfg_enable = 1'b0;
        cfg_base = 32'h8000;
        cfg_size = 32'h1000;
        host_rd_ptr = 32'd0;
        pkt_valid = 1'b0;
        pkt_len = 16'd0;
        #2 reset_n = 1'b0;
        #1;
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_wr_ctrl", {31'b0, wr_ctrl}, 32'd0);
        chk("rst_pkt_ack", {31'b0, pkt_ack}, 32'd0);
        chk("rst_wr_ptr", wr_ptr, 32'd0);
        chk("rst_pkt_count", pkt_count, 32'd0);
        chk("rst_err", {31'b0, err}, 32'd0);
        cyc(2);
        reset_n = 1'b1;
        cyc(2);
        cfg_enable = 1'b1;
        cyc(2);

        // basic write
        send(16'h0100);
        chk("basic_latency", lat, 32'd2);
        chk("basic_wr_ctrl", {31'b0, s_wrc}, 32'd1);
        chk("basic_addr", s_addr, 32'h8000);
        chk("basic_end", s_end, 32'h100);
        chk("basic_control", s_ctrl, 32'h100);
        chk("basic_begin", s_begin, 32'd0);
        wait_idle("basic_idle");
        chk("basic_wr_ptr", wr_ptr, 32'h110);
        chk("basic_pkt_count", pkt_count, 32'd1);
        chk("basic_ack_cnt", ack_cnt, 32'd1);
        chk("basic_wrc_cnt", wrc_cnt, 32'd1);

        // padding: 61 bytes rounds to 64, record 80
        send(16'd61);
        chk("pad_addr", s_addr, 32'h8110);
        chk("pad_end", s_end, 32'd64);
        chk("pad_control", s_ctrl, 32'd61);
        wait_idle("pad_idle");
        chk("pad_wr_ptr", wr_ptr, 32'h160);
        chk("pad_pkt_count", pkt_count, 32'd2);

        // fill to 0xFF0, then wrap
        send(16'h0E80);
        chk("fill_addr", s_addr, 32'h8160);
        wait_idle("fill_idle");
        chk("fill_wr_ptr", wr_ptr, 32'hFF0);
        host_rd_ptr = 32'hF00;
        send(16'd32);
        chk("wrap_latency", lat, 32'd2);
        chk("wrap_addr", s_addr, 32'h8000);
        chk("wrap_end", s_end, 32'd32);
        wait_idle("wrap_idle");
        chk("wrap_wr_ptr", wr_ptr, 32'h30);
        chk("wrap_pkt_count", pkt_count, 32'd4);

        // shrink buffer to 0x100 via a new enable edge, fill to 0xE0, then drop
        cfg_enable = 1'b0;
        cfg_size = 32'h100;
        host_rd_ptr = 32'd0;
        cyc(2);
        cfg_enable = 1'b1;
        cyc(2);
        chk("reen_wr_ptr", wr_ptr, 32'd0);
        send(16'h00D0);
        wait_idle("small_idle");
        chk("small_wr_ptr", wr_ptr, 32'hE0);
        send(16'd16);
        chk("drop_latency", lat, 32'd1);
        chk("drop_no_strobe", {31'b0, s_wrc}, 32'd0);
        wait_idle("drop_idle");
        chk("drop_count", drop_count, 32'd1);
        chk("drop_wr_ptr", wr_ptr, 32'hE0);
        chk("drop_wrc_cnt", wrc_cnt, 32'd5);
        chk("drop_pkt_count", pkt_count, 32'd5);
        host_rd_ptr = 32'h80;
        send(16'd16);
        chk("refill_wr_ctrl", {31'b0, s_wrc}, 32'd1);
        chk("refill_addr", s_addr, 32'h80E0);
        wait_idle("refill_idle");
        chk("refill_wr_ptr_exact_end", wr_ptr, 32'd0);
        chk("refill_pkt_count", pkt_count, 32'd6);

        // start timeout: rdy never falls
        model_busy = 0;
        send(16'd4);
        chk("tmo_addr", s_addr, 32'h8000);
        chk("tmo_end", s_end, 32'd4);
        cyc(8);
        chk("tmo_err_before", {31'b0, err}, 32'd0);
        chk("tmo_busy_before", {31'b0, busy}, 32'd1);
        cyc(1);
        chk("tmo_err_set", {31'b0, err}, 32'd1);
        cyc(1);
        chk("tmo_idle", {31'b0, busy}, 32'd0);
        chk("tmo_wr_ptr", wr_ptr, 32'h14);
        chk("tmo_pkt_count", pkt_count, 32'd7);
        model_busy = 70;

        // enable low: descriptor must not be taken
        cfg_enable = 1'b0;
        pkt_len = 16'd4;
        pkt_valid = 1'b1;
        cyc(4);
        chk("dis_busy", {31'b0, busy}, 32'd0);
        chk("dis_ack_cnt", ack_cnt, 32'd8);
        pkt_valid = 1'b0;
        cfg_enable = 1'b1;
        cyc(2);
        chk("dis_reen_wr_ptr", wr_ptr, 32'd0);

        // reset in WAIT_DONE
        send(16'd8);
        chk("rstmid_addr", s_addr, 32'h8000);
        cyc(5);
        chk("rstmid_busy", {31'b0, busy}, 32'd1);
        #2;
        cfg_base = 32'h4000;
        reset_n = 1'b0;
        #1;
        chk("rstmid_busy_async", {31'b0, busy}, 32'd0);
        chk("rstmid_err_async", {31'b0, err}, 32'd0);
        chk("rstmid_wr_ptr_async", wr_ptr, 32'd0);
        chk("rstmid_pkt_count_async", pkt_count, 32'd0);
        chk("rstmid_drop_async", drop_count, 32'd0);
        chk("rstmid_addr_async", write_address, 32'd0);
        chk("rstmid_control_async", control, 32'd0);
        cyc(2);
        reset_n = 1'b1;
        cfg_enable = 1'b0;
        cyc(80);
        cfg_enable = 1'b1;
        cyc(2);
        send(16'd4);
        chk("post_latency", lat, 32'd2);
        chk("post_addr", s_addr, 32'h4000);
        wait_idle("post_idle");
        chk("post_wr_ptr", wr_ptr, 32'h14);
        chk("post_pkt_count", pkt_count, 32'd1);
        chk("post_ack_cnt", ack_cnt, 32'd10);
        chk("post_wrc_cnt", wrc_cnt, 32'd9);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pkt_sched.md
Name: pkt_sched

Overview:
- Sequences `wr_ctrl` for packet capture. Takes one packet descriptor (byte length) at a time from the ingress side.
- Allocates space for the record in a host-visible circular capture buffer in DDR, then issues a one-cycle `wr_ctrl` start with `write_address`/`pkt_begin`/`pkt_end`/`control` and waits for `wr_ctrl_rdy`.
- Drops descriptors that do not fit, advances the write pointer with wrap-around, and keeps packet, drop and error statistics for the host.

Parameters:
- `HDR_BYTES`, 16, bytes reserved per record ahead of payload (timestamp header written by `wr_ctrl`).
- `START_TMO`, 8, cycles allowed for `wr_ctrl_rdy` to fall after a start pulse.

Ports:
- `clk`  in  1  system clock
- `reset_n`  in  1  asynchronous active-low reset
- `cfg_enable`  in  1  capture enable (host CSR)
- `cfg_base`  in  32  byte address of buffer start, 4-byte aligned
- `cfg_size`  in  32  buffer size in bytes, multiple of 4, at least 64
- `host_rd_ptr`  in  32  byte offset up to which the host has consumed records
- `pkt_valid`  in  1  descriptor available
- `pkt_len`  in  16  packet length in bytes, 1..65535
- `pkt_ack`  out  1  one-cycle pulse: descriptor consumed (written or dropped)
- `wr_ctrl`  out  1  one-cycle start strobe to `wr_ctrl`
- `control`  out  32  {16'b0, `pkt_len`}
- `pkt_begin`  out  32  always 0
- `pkt_end`  out  32  payload bytes rounded up to multiple of 4
- `write_address`  out  32  `cfg_base` + record offset
- `wr_ctrl_rdy`  in  1  high when `wr_ctrl` is idle
- `wr_ptr`  out  32  current write offset (bytes, 0..`cfg_size`-4)
- `pkt_count`  out  32  records issued
- `drop_count`  out  32  descriptors dropped for lack of space
- `err`  out  1  sticky: start timeout occurred
- `busy`  out  1  high in any state except IDLE

Behaviour:
- Reset: all outputs 0 and FSM in IDLE, taking effect immediately on `reset_n` low, even mid-transfer.
- Width and arithmetic rules:
  - pad = (`pkt_len`+3) & ~3
  - rec = `HDR_BYTES` + pad, 17 bits
  - used = (`wr_ptr` − `host_rd_ptr`) mod `cfg_size`
  - free = `cfg_size` − used − 4; one word is always kept empty, so equal pointers mean empty.
- Rising edge of `cfg_enable`, detected in IDLE: `wr_ptr` ← 0; `cfg_base`/`cfg_size` sampled into internal registers and held until the next rising edge.
- IDLE: if `cfg_enable` && `pkt_valid` → CHECK. Otherwise stay.
- CHECK (1 cycle):
  - If `wr_ptr` + rec > `cfg_size`, set tail = `cfg_size` − `wr_ptr` and off = 0. Otherwise tail = 0 and off = `wr_ptr`.
  - If tail + rec > free: `drop_count`++, `pkt_ack`=1, → IDLE.
  - Else latch off and pad, → ISSUE.
- ISSUE (1 cycle):
  - Only entered when `wr_ctrl_rdy`=1; otherwise wait in ISSUE with `wr_ctrl`=0.
  - When entered: `wr_ctrl`=1; `write_address` = base + off; `pkt_end` = pad; `control` = {16'b0, `pkt_len`}; `pkt_ack`=1 in the same cycle. → WAIT_START.
  - Address/begin/end/control hold stable until the next ISSUE.
- WAIT_START:
  - `wr_ctrl_rdy`=0 → WAIT_DONE.
  - `START_TMO` cycles elapse with `wr_ctrl_rdy` still 1 → `err` ← 1, → ADVANCE.
- WAIT_DONE: `wr_ctrl_rdy`=1 → ADVANCE.
- ADVANCE (1 cycle):
  - `wr_ptr` ← off + rec, or 0 if that equals `cfg_size`.
  - `pkt_count`++. → IDLE.
- Descriptor latency: start strobe 2 cycles after `pkt_valid` is seen in IDLE with `wr_ctrl_rdy` high. Minimum record period is 5 cycles plus the `wr_ctrl` busy time.
- `cfg_enable` low mid-record: the current record completes through ADVANCE, then the FSM stays in IDLE. No new descriptors are acked.
- `pkt_valid` while busy: ignored until IDLE; the upstream holds the descriptor until `pkt_ack`.
- Counters wrap modulo 2^32. `err` clears only on reset.

Test Plan:
- Basic write: `cfg_base`=0x8000, `cfg_size`=0x1000, `host_rd_ptr`=0, `pkt_len`=0x100, with a `wr_ctrl` model (rdy low 70 cycles) → `wr_ctrl` pulse 2 cycles after valid, `write_address`=0x8000, `pkt_end`=0x100, `control`=0x100, `pkt_ack` once, `wr_ptr`=0x110, `pkt_count`=1.
- Padding: `pkt_len`=61 → `pkt_end`=64, `wr_ptr` advances by 80.
- Wrap: `wr_ptr`=0xFF0, `host_rd_ptr`=0xF00, `pkt_len`=32 → tail 16 skipped, `write_address`=0x8000, `wr_ptr`=0x30.
- Full/drop: `cfg_size`=0x100, `host_rd_ptr`=0, `wr_ptr`=0xE0, `pkt_len`=16 → free=28 < 32 → no `wr_ctrl` pulse, `drop_count`=1, `pkt_ack` pulses, `wr_ptr` unchanged. Host moves `host_rd_ptr` to 0x80 → next `pkt_len`=16 is written.
- Timeout: `wr_ctrl_rdy` held high → after 8 cycles `err`=1, `wr_ptr` advances, FSM returns to IDLE.
- Reset mid WAIT_DONE: drop `reset_n` → all outputs 0 asynchronously. After release plus an enable edge, `wr_ptr`=0 and the next descriptor is written at `cfg_base`.
